// File: rtl/srl_fifo_ctrl.sv
// Purpose : control for an SRL-based FIFO; drives shift/address of an external storage array
//           and keeps a first-word-fall-through head register with write bypass.
// Latency : 1 cycle from write to if_dout when empty; stored words reach the head in order.
// Backpr. : if_full_n drops when storage holds DEPTH words and never depends on a same-cycle pop;
//           a rejected write/read sets a sticky error flag and changes nothing else.
// Ports   : ap_clk/ap_rst_n clock and async active-low reset;
//           if_write_ce/if_write/if_din/if_full_n producer side;
//           if_read_ce/if_read/if_dout/if_empty_n consumer side;
//           if_count occupancy, if_prog_full registered threshold flag;
//           err_clr/err_ovf/err_udf sticky error flags;
//           srl_we/srl_addr/srl_din/srl_dout storage array interface.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 17,
    parameter int PROG_FULL  = 14,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_WIDTH-1:0]  if_count,
    output logic                  if_prog_full,
    input  logic                  err_clr,
    output logic                  err_ovf,
    output logic                  err_udf,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH:0]   PFULL_C = (CNT_WIDTH+1)'(PROG_FULL);

    logic [CNT_WIDTH-1:0]  n_q, n_d;
    logic                  dv_q, dv_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  pfull_q, pfull_d;

    logic full_int;
    logic push, pop, slot, n_zero, bypass, load, we;
    logic ovf_set, udf_set;

    // Full depends only on storage occupancy, so a same-cycle pop never opens a slot.
    assign full_int = (n_q < DEPTH_C);
    assign push     = if_write & if_write_ce & full_int;
    assign pop      = if_read & if_read_ce & dv_q;
    // Head register is free at this edge: either empty or being popped now.
    assign slot     = ~dv_q | pop;
    assign n_zero   = (n_q == '0);
    assign bypass   = push & n_zero & slot;
    // Oldest stored word sits at addr_q = N-1 and is read before the shift lands.
    assign load     = ~n_zero & slot;
    assign we       = push & ~bypass;

    assign ovf_set  = if_write & if_write_ce & ~full_int;
    assign udf_set  = if_read & if_read_ce & ~dv_q;

    always_comb begin
        n_d    = n_q + CNT_WIDTH'(we) - CNT_WIDTH'(load);
        addr_d = (n_d == '0) ? '0 : ADDR_WIDTH'(n_d - 1'b1);

        dv_d   = dv_q;
        dout_d = dout_q;
        if (bypass) begin
            dout_d = if_din;
            dv_d   = 1'b1;
        end else if (load) begin
            dout_d = srl_dout;
            dv_d   = 1'b1;
        end else if (pop) begin
            dv_d   = 1'b0;
        end

        pfull_d = (({1'b0, n_d} + (CNT_WIDTH+1)'(dv_d)) >= PFULL_C);

        // A new error in the same cycle wins over the clear.
        ovf_d = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        udf_d = udf_set ? 1'b1 : (err_clr ? 1'b0 : udf_q);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            n_q     <= '0;
            dv_q    <= 1'b0;
            dout_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pfull_q <= 1'b0;
        end else begin
            n_q     <= n_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pfull_q <= pfull_d;
        end
    end

    // Handshakes are held inactive for the whole time reset is asserted.
    assign if_full_n    = ap_rst_n & full_int;
    assign if_empty_n   = ap_rst_n & dv_q;
    assign if_dout      = dout_q;
    assign if_count     = n_q + CNT_WIDTH'(dv_q);
    assign if_prog_full = pfull_q;
    assign err_ovf      = ovf_q;
    assign err_udf      = udf_q;
    assign srl_we       = we;
    assign srl_addr     = addr_q;
    assign srl_din      = if_din;

endmodule
